ring_nic: RTL and testbench

- Network interface controller: the processor-side end of one ring router's PE port.
- Presents a 4-register load/store interface to a processor core.
- Injects one packet into the router, gated by the router's polarity.
- Accepts one packet ejected by the router.
- One instance per ring node, sitting between the core and the router's PE send/receive handshake pins.

---
 rtl/ring_nic.sv | 118 +++++++++++
 tb/tb_ring_nic.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ring_nic.sv
// Ring NIC: processor-side end of a ring router PE port with one TX and one RX packet buffer.
// Optional per-direction packet counters on the status registers under `NIC_PKT_CNT_EN.
module ring_nic #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned VC_BIT     = 63
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            addr,
  input  logic [DATA_WIDTH-1:0] d_in,
  output logic [DATA_WIDTH-1:0] d_out,
  input  logic                  nic_en,
  input  logic                  nic_wr_en,
  output logic                  net_so,
  input  logic                  net_ro,
  output logic [DATA_WIDTH-1:0] net_do,
  input  logic                  net_si,
  output logic                  net_ri,
  input  logic [DATA_WIDTH-1:0] net_di,
  input  logic                  net_polarity
);

  localparam logic [1:0] AddrRxBuf  = 2'd0;
  localparam logic [1:0] AddrRxStat = 2'd1;
  localparam logic [1:0] AddrTxBuf  = 2'd2;
  localparam logic [1:0] AddrTxStat = 2'd3;

  logic [DATA_WIDTH-1:0] rx_buf_q, rx_buf_d;
  logic                  rx_full_q, rx_full_d;
  logic [DATA_WIDTH-1:0] tx_buf_q, tx_buf_d;
  logic                  tx_full_q, tx_full_d;
  logic [DATA_WIDTH-1:0] d_out_q, d_out_d;

  logic                  rd_req, wr_req, rx_accept, tx_send;
  logic [DATA_WIDTH-1:0] rx_stat, tx_stat;

  assign rd_req    = nic_en & ~nic_wr_en;
  assign wr_req    = nic_en & nic_wr_en;
  assign net_ri    = ~rx_full_q;
  assign rx_accept = net_si & ~rx_full_q;
  // Only inject when the packet's VC tag matches the router's current cycle parity.
  assign tx_send   = tx_full_q & net_ro & (tx_buf_q[VC_BIT] == net_polarity);
  assign net_so    = tx_send;
  assign net_do    = tx_buf_q;
  assign d_out     = d_out_q;

`ifdef NIC_PKT_CNT_EN
  logic [7:0] rx_cnt_q, tx_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_cnt_q <= '0;
      tx_cnt_q <= '0;
    end else begin
      if (rx_accept) rx_cnt_q <= rx_cnt_q + 8'd1;
      if (tx_send)   tx_cnt_q <= tx_cnt_q + 8'd1;
    end
  end

  assign rx_stat = {{(DATA_WIDTH-16){1'b0}}, rx_cnt_q, 7'b0, rx_full_q};
  assign tx_stat = {{(DATA_WIDTH-16){1'b0}}, tx_cnt_q, 7'b0, tx_full_q};
`else
  assign rx_stat = {{(DATA_WIDTH-1){1'b0}}, rx_full_q};
  assign tx_stat = {{(DATA_WIDTH-1){1'b0}}, tx_full_q};
`endif

  always_comb begin
    rx_buf_d  = rx_buf_q;
    rx_full_d = rx_full_q;
    tx_buf_d  = tx_buf_q;
    tx_full_d = tx_full_q;
    d_out_d   = d_out_q;

    // rx_accept needs rx_full=0 and the read-clear needs rx_full=1, so they never collide.
    if (rx_accept) begin
      rx_buf_d  = net_di;
      rx_full_d = 1'b1;
    end

    if (tx_send) tx_full_d = 1'b0;

    // Write sees pre-edge tx_full, so a write racing a send is dropped.
    if (wr_req && addr == AddrTxBuf && !tx_full_q) begin
      tx_buf_d  = d_in;
      tx_full_d = 1'b1;
    end

    if (rd_req) begin
      case (addr)
        AddrRxBuf: begin
          d_out_d = rx_buf_q;
          if (rx_full_q) rx_full_d = 1'b0;
        end
        AddrRxStat: d_out_d = rx_stat;
        AddrTxBuf:  d_out_d = '0;
        AddrTxStat: d_out_d = tx_stat;
        default:    d_out_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_buf_q  <= '0;
      rx_full_q <= 1'b0;
      tx_buf_q  <= '0;
      tx_full_q <= 1'b0;
      d_out_q   <= '0;
    end else begin
      rx_buf_q  <= rx_buf_d;
      rx_full_q <= rx_full_d;
      tx_buf_q  <= tx_buf_d;
      tx_full_q <= tx_full_d;
      d_out_q   <= d_out_d;
    end
  end

endmodule

// File: tb/tb_ring_nic.sv
// Directed, table-driven bench for ring_nic plus hand sequences for reset and counter wrap.
module tb_ring_nic;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic [63:0] d_in, d_out, net_do, net_di;
  logic        nic_en, nic_wr_en, net_so, net_ro, net_si, net_ri, net_polarity;

  int total = 0;
  int bad   = 0;

  ring_nic #(.DATA_WIDTH(64), .VC_BIT(63)) dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .d_in         (d_in),
    .d_out        (d_out),
    .nic_en       (nic_en),
    .nic_wr_en    (nic_wr_en),
    .net_so       (net_so),
    .net_ro       (net_ro),
    .net_do       (net_do),
    .net_si       (net_si),
    .net_ri       (net_ri),
    .net_di       (net_di),
    .net_polarity (net_polarity)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en, wr;
    logic [1:0]  addr;
    logic [63:0] din;
    logic        ro, si;
    logic [63:0] di;
    logic        pol;
    logic        so, ri;   // expected combinational outputs before the edge
    logic [63:0] nd;       // expected net_do before the edge
    logic        stat;     // expected d_out is a status word
    logic [7:0]  cnt;      // counter field of that status word (counter build only)
    logic [63:0] dout;     // expected d_out after the edge
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t mk(logic en, logic wr, logic [1:0] a, logic [63:0] din, logic ro,
                              logic si, logic [63:0] di, logic pol, logic so, logic ri,
                              logic [63:0] nd, logic stat, logic [7:0] cnt, logic [63:0] dout);
    vec_t v;
    v.en = en; v.wr = wr; v.addr = a; v.din = din; v.ro = ro; v.si = si; v.di = di;
    v.pol = pol; v.so = so; v.ri = ri; v.nd = nd; v.stat = stat; v.cnt = cnt; v.dout = dout;
    return v;
  endfunction

  function automatic logic [63:0] exp_stat(logic stat, logic [7:0] cnt, logic [63:0] base);
`ifdef NIC_PKT_CNT_EN
    if (stat) return base | {48'b0, cnt, 8'b0};
`endif
    return base;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    nic_en = 0; nic_wr_en = 0; addr = 0; d_in = 0; net_si = 0; net_di = 0;
  endtask

  localparam logic [63:0] PktA = 64'h8000_0000_0000_00AA;
  localparam logic [63:0] PktB = 64'h0000_0000_0000_0055;
  localparam logic [63:0] PktR = 64'h0000_1234_5678_9ABC;

  initial begin
    idle();
    net_ro = 0; net_polarity = 0; reset = 0;

    //          en wr a  din        ro si di        pol so ri nd   st cnt  dout
    vecs[0]  = mk(1, 0, 1, 0,          0, 0, 0,        0, 0, 1, 0,    1, 0, 0);
    vecs[1]  = mk(1, 0, 3, 0,          0, 0, 0,        1, 0, 1, 0,    1, 0, 0);
    vecs[2]  = mk(1, 1, 2, PktA,       1, 0, 0,        1, 0, 1, 0,    1, 0, 0);
    vecs[3]  = mk(0, 0, 0, 0,          1, 0, 0,        0, 0, 1, PktA, 1, 0, 0);
    vecs[4]  = mk(0, 0, 0, 0,          1, 0, 0,        1, 1, 1, PktA, 1, 0, 0);
    vecs[5]  = mk(1, 0, 3, 0,          1, 0, 0,        0, 0, 1, PktA, 1, 1, 0);
    vecs[6]  = mk(1, 1, 2, PktB,       0, 0, 0,        0, 0, 1, PktA, 1, 1, 0);
    vecs[7]  = mk(1, 1, 2, 64'h1,      0, 0, 0,        1, 0, 1, PktB, 1, 1, 0);
    vecs[8]  = mk(1, 0, 3, 0,          0, 0, 0,        0, 0, 1, PktB, 1, 1, 1);
    vecs[9]  = mk(1, 0, 2, 0,          1, 0, 0,        1, 0, 1, PktB, 0, 0, 0);
    vecs[10] = mk(1, 1, 2, 64'h77,     1, 0, 0,        0, 1, 1, PktB, 0, 0, 0);
    vecs[11] = mk(1, 0, 3, 0,          1, 0, 0,        1, 0, 1, PktB, 1, 2, 0);
    vecs[12] = mk(0, 0, 0, 0,          0, 1, PktR,     0, 0, 1, PktB, 1, 2, 0);
    vecs[13] = mk(1, 0, 1, 0,          0, 1, 64'hDEAD, 1, 0, 0, PktB, 1, 1, 1);
    vecs[14] = mk(1, 0, 0, 0,          0, 0, 0,        0, 0, 0, PktB, 0, 0, PktR);
    vecs[15] = mk(1, 0, 1, 0,          0, 0, 0,        1, 0, 1, PktB, 1, 1, 0);
    vecs[16] = mk(1, 0, 0, 0,          0, 0, 0,        0, 0, 1, PktB, 0, 0, PktR);
    vecs[17] = mk(1, 1, 0, 64'hFFFF,   0, 0, 0,        1, 0, 1, PktB, 0, 0, PktR);
    vecs[18] = mk(1, 0, 1, 0,          0, 0, 0,        0, 0, 1, PktB, 1, 1, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1;
    #1;
    check("reset d_out", d_out, 64'h0);
    check("reset net_so", {63'b0, net_so}, 64'h0);
    check("reset net_ri", {63'b0, net_ri}, 64'h1);
    check("reset net_do", net_do, 64'h0);

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      nic_en = vecs[i].en; nic_wr_en = vecs[i].wr; addr = vecs[i].addr; d_in = vecs[i].din;
      net_ro = vecs[i].ro; net_si = vecs[i].si; net_di = vecs[i].di;
      net_polarity = vecs[i].pol;
      #1;
      check($sformatf("v%0d net_so", i), {63'b0, net_so}, {63'b0, vecs[i].so});
      check($sformatf("v%0d net_ri", i), {63'b0, net_ri}, {63'b0, vecs[i].ri});
      check($sformatf("v%0d net_do", i), net_do, vecs[i].nd);
      @(posedge clk);
      #1;
      check($sformatf("v%0d d_out", i), d_out,
            exp_stat(vecs[i].stat, vecs[i].cnt, vecs[i].dout));
    end

    // Polarity-gated send with a bounded wait: VC=1 packet must go within 2 cycles.
    @(negedge clk);
    idle(); net_ro = 1; net_polarity = 0;
    nic_en = 1; nic_wr_en = 1; addr = 2; d_in = PktA;
    @(posedge clk);
    begin
      bit seen = 0;
      for (int c = 0; c < 4 && !seen; c++) begin
        @(negedge clk);
        idle();
        net_polarity = ~net_polarity;
        #1;
        if (net_so) begin
          seen = 1;
          check("gated send polarity", {63'b0, net_polarity}, 64'h1);
        end
      end
      if (!seen) check("gated send timeout", 64'h0, 64'h1);
    end
    @(posedge clk);

    // Asynchronous reset with both buffers full discards everything.
    @(negedge clk);
    idle(); net_ro = 0;
    nic_en = 1; nic_wr_en = 1; addr = 2; d_in = 64'hC3; net_si = 1; net_di = 64'h99;
    @(posedge clk);
    @(negedge clk);
    idle(); nic_en = 1; addr = 3;
    @(posedge clk);
    #2;
    check("pre-reset d_out", d_out[0 +: 1] == 1'b1 ? 64'h1 : 64'h0, 64'h1);
    check("pre-reset net_ri", {63'b0, net_ri}, 64'h0);
    reset = 0;
    #1;
    check("async reset net_ri", {63'b0, net_ri}, 64'h1);
    check("async reset net_do", net_do, 64'h0);
    check("async reset d_out", d_out, 64'h0);
    @(negedge clk);
    reset = 1;
    idle(); nic_en = 1; addr = 3;
    @(posedge clk);
    #1;
    check("post-reset tx status", d_out, 64'h0);

`ifdef NIC_PKT_CNT_EN
    for (int i = 0; i < 257; i++) begin
      @(negedge clk);
      idle(); net_si = 1; net_di = 64'(i);
      @(posedge clk);
      @(negedge clk);
      idle(); nic_en = 1; addr = 0;
      @(posedge clk);
    end
    @(negedge clk);
    idle(); nic_en = 1; addr = 1;
    @(posedge clk);
    #1;
    check("rx_cnt wrap", d_out, {48'b0, 8'h01, 8'h00});
`endif

    @(negedge clk);
    idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
